servo_cmd_sched: RTL
====================

// Module: servo_cmd_sched
// PURPOSE
//  Command scheduler between the HM-10 UART byte receiver, servo PWM generator and UART transmitter.
//  Decodes received ASCII commands into mode/position and runs the mode-B position cycle on a dwell timer.
//  Reports every state change to the phone as a 2-byte status ("A3", "B5", ...) over a valid/ready TX port.
// PARAMETERS
//  DWELL_CYC  50_000_000  mode-B dwell per position, in CLK cycles (1 s at 50 MHz); must be >= 16
//  NPOS       5           number of servo positions (digits '1'..NPOS); 2..9
// PORTS
//  CLK       in   1     system clock, all logic on rising edge
//  RESET     in   1     asynchronous, active-high reset
//  rx_data   in   8     received byte
//  rx_valid  in   1     one-cycle strobe, rx_data valid
//  tx_data   out  8     status byte to UART TX
//  tx_valid  out  1     tx_data valid; held until accepted
//  tx_ready  in   1     TX accepts byte on cycle tx_valid && tx_ready
//  sel_modo  out  1     0 = mode A (manual), 1 = mode B (auto cycle)
//  pos_sel   out  NPOS  one-hot servo position select
//  cmd_err   out  1     one-cycle pulse on rejected byte
// BEHAVIOUR
//  Reset: sel_modo=0, pos_sel=1 (pos 1), tx_valid=0, tx_data=0, cmd_err=0, dwell cnt=0, report pending=0.
//  All outputs registered; decode latency 1 cycle (rx_valid at N -> outputs change at N+1).
//  Decode: 'A'/'a' -> sel_modo=0, position held. 'B'/'b' -> sel_modo=1, dwell cnt cleared.
//   '1'..NPOS digit in mode A -> pos_sel one-hot bit (digit-1). Digit in mode B -> cmd_err, no change.
//   Any other byte (incl. '0', digit > NPOS) -> cmd_err, no state change, no report.
//  Every accepted command sets report pending, even when state is unchanged.
//  Mode B: dwell cnt counts 0..DWELL_CYC-1; at terminal count it wraps to 0, pos advances 1->2..->NPOS->1, report pending set.
//   Mode A: dwell cnt held at 0.
//  Same cycle rx_valid + dwell terminal: command wins; the advance is dropped and cnt restarts at 0.
//  TX FSM: IDLE -> SEND_MODE -> SEND_POS -> IDLE.
//   IDLE with pending: load tx_data = 'A'/'B' from sel_modo, tx_valid=1, clear pending, go SEND_MODE.
//   SEND_MODE on handshake: tx_data = '1'+pos index, sampled at this handshake; go SEND_POS.
//   SEND_POS on handshake: tx_valid=0, go IDLE.
//   Events during a transfer set pending again (coalesced, never queued). Re-send starts from IDLE next cycle.
//   tx_data stable while tx_valid && !tx_ready; tx_ready ignored when tx_valid=0.
//  RESET mid-transfer: tx_valid drops asynchronously; the partial status is abandoned, no resume.
// CONFIGURATION
//  SERVO_SPEED_CMD_EN defined: 2-bit speed shift s (reset 0); effective dwell = DWELL_CYC >> s.
//   '+' -> s = min(s+1, 3); '-' -> s = max(s-1, 0). Both accepted, report pending, dwell cnt cleared.
//  Not defined: '+'/'-' are invalid bytes (cmd_err); dwell fixed at DWELL_CYC; no shift register.
// STRUCTURE
//  Package servo_cmd_pkg:
//   ASCII constants (CH_A, CH_B, CH_a, CH_b, CH_0, CH_PLUS, CH_MINUS).
//   TX FSM state encoding (ST_IDLE, ST_SEND_MODE, ST_SEND_POS).
//  Sub-module servo_status_tx: TX FSM plus pending flag.
//   Inputs: report request, sel_modo, pos index. Outputs: tx_data/tx_valid.
//  Top holds decoder, mode/pos registers and dwell counter ($clog2(DWELL_CYC) bits).
// TESTING (bench: DWELL_CYC=16, NPOS=5, tx_ready driven by bench)
//  1. Reset, rx '3' with tx_ready=1:
//     pos_sel=00100 next cycle, cmd_err=0; TX emits 0x41 then 0x33.
//  2. rx 'B', hold tx_ready=1:
//     sel_modo=1; pos advances every 16 cycles 3->4->5->1->2.
//     One "Bn" status pair sent per advance.
//  3. In mode B, rx '2': cmd_err pulses 1 cycle; pos/mode unchanged; no TX.
//     Then rx 'x' (0x78): cmd_err pulses again.
//  4. tx_ready=0, rx 'A' then '4' then '5':
//     tx_valid=1, tx_data=0x41 held stable.
//     Raise tx_ready: exactly "A5" sent for the '4'/'5' events (coalesced), 4 bytes total.
//  5. Mode B, rx 'A' on the dwell terminal cycle: pos unchanged, sel_modo=0.
//     Assert RESET while tx_valid=1: tx_valid=0 immediately, pos_sel=00001.
//  6. With SERVO_SPEED_CMD_EN: rx '+' x4 -> dwell 16, 8, 4, 2, 2 cycles.
//     Without it: '+' gives cmd_err pulse.

Source files
------------

// File: rtl/servo_cmd_pkg.sv
// servo_cmd_pkg: shared ASCII constants and status TX state encoding
// for the servo command scheduler.
package servo_cmd_pkg;

    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_B     = 8'h42;
    localparam logic [7:0] CH_a     = 8'h61;
    localparam logic [7:0] CH_b     = 8'h62;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_MODE,
        ST_SEND_POS
    } tx_state_t;

    // ASCII digit for a zero-based position index
    function automatic logic [7:0] pos_char(input logic [7:0] idx);
        return CH_0 + idx + 8'd1;
    endfunction

endpackage

// File: rtl/servo_cmd_sched_if.sv
// servo_cmd_sched_if: UART RX strobe and TX valid/ready bundle
// between the HM-10 byte link and the command scheduler.
interface servo_cmd_sched_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/servo_status_tx.sv
// servo_status_tx: sends the 2-byte mode/position status whenever a
// report is pending; reports raised mid-transfer coalesce into one re-send.
module servo_status_tx
    import servo_cmd_pkg::*;
#(
    parameter int PW = 3
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          report,
    input  logic          sel_modo,
    input  logic [PW-1:0] pos_idx,
    input  logic          tx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid
);

    tx_state_t  state_q;
    tx_state_t  state_d;
    logic       pend_q;
    logic       pend_d;
    logic [7:0] data_d;
    logic       valid_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            tx_data  <= data_d;
            tx_valid <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | report;
        data_d  = tx_data;
        valid_d = tx_valid;
        unique case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    data_d  = sel_modo ? CH_B : CH_A;
                    valid_d = 1'b1;
                    pend_d  = report;
                    state_d = ST_SEND_MODE;
                end
            end
            ST_SEND_MODE: begin
                // position is sampled on the mode-byte handshake
                if (tx_ready) begin
                    data_d  = pos_char(8'(pos_idx));
                    state_d = ST_SEND_POS;
                end
            end
            ST_SEND_POS: begin
                if (tx_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/servo_cmd_sched.sv
// servo_cmd_sched: ASCII command decoder, mode-B dwell cycler and status reporter.
// Optional macro SERVO_SPEED_CMD_EN adds '+'/'-' dwell speed shift commands.
module servo_cmd_sched
    import servo_cmd_pkg::*;
#(
    parameter int DWELL_CYC = 50_000_000,
    parameter int NPOS      = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    servo_cmd_sched_if.slave bus,
    output logic             sel_modo,
    output logic [NPOS-1:0]  pos_sel,
    output logic             cmd_err
);

    localparam int CW = $clog2(DWELL_CYC);
    localparam int PW = $clog2(NPOS);

    localparam logic [7:0]    CH_1     = CH_0 + 8'd1;
    localparam logic [7:0]    CH_LAST  = CH_0 + 8'(NPOS);
    localparam logic [PW-1:0] IDX_LAST = PW'(NPOS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] last_cnt;
    logic [PW-1:0] pos_idx;
    logic [PW-1:0] dig_idx;
    logic [PW-1:0] nxt_idx;
    logic          is_a;
    logic          is_b;
    logic          is_dig;
    logic          cmd_ok;
    logic          accept;
    logic          reject;
    logic          term;
    logic          report;

`ifdef SERVO_SPEED_CMD_EN
    logic [1:0] shift_q;
    logic       is_up;
    logic       is_dn;

    assign is_up    = bus.rx_data == CH_PLUS;
    assign is_dn    = bus.rx_data == CH_MINUS;
    assign last_cnt = CW'((DWELL_CYC >> shift_q) - 1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            shift_q <= 2'd0;
        else if (bus.rx_valid && is_up && shift_q != 2'd3)
            shift_q <= shift_q + 2'd1;
        else if (bus.rx_valid && is_dn && shift_q != 2'd0)
            shift_q <= shift_q - 2'd1;
    end
`else
    assign last_cnt = CW'(DWELL_CYC - 1);
`endif

    always_comb begin
        is_a    = (bus.rx_data == CH_A) || (bus.rx_data == CH_a);
        is_b    = (bus.rx_data == CH_B) || (bus.rx_data == CH_b);
        is_dig  = (bus.rx_data >= CH_1) && (bus.rx_data <= CH_LAST);
        dig_idx = PW'(bus.rx_data - CH_1);
        cmd_ok  = is_a || is_b || (is_dig && !sel_modo);
`ifdef SERVO_SPEED_CMD_EN
        cmd_ok  = cmd_ok || is_up || is_dn;
`endif
        accept  = bus.rx_valid && cmd_ok;
        reject  = bus.rx_valid && !cmd_ok;
        term    = sel_modo && (cnt_q == last_cnt);
        report  = accept || term;
        nxt_idx = (pos_idx == IDX_LAST) ? '0 : pos_idx + 1'b1;
    end

    // an accepted command on the terminal cycle drops that advance
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sel_modo <= 1'b0;
            pos_idx  <= '0;
            pos_sel  <= NPOS'(1);
            cnt_q    <= '0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_err <= reject;
            if (accept) begin
                cnt_q <= '0;
                unique case (1'b1)
                    is_a: sel_modo <= 1'b0;
                    is_b: sel_modo <= 1'b1;
                    is_dig: begin
                        pos_idx <= dig_idx;
                        pos_sel <= NPOS'(1) << dig_idx;
                    end
                    default: ;
                endcase
            end else if (term) begin
                cnt_q   <= '0;
                pos_idx <= nxt_idx;
                pos_sel <= NPOS'(1) << nxt_idx;
            end else if (sel_modo) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    servo_status_tx #(
        .PW (PW)
    ) u_status_tx (
        .CLK      (CLK),
        .RESET    (RESET),
        .report   (report),
        .sel_modo (sel_modo),
        .pos_idx  (pos_idx),
        .tx_ready (bus.tx_ready),
        .tx_data  (bus.tx_data),
        .tx_valid (bus.tx_valid)
    );

endmodule
